// File: rtl/mux_scan_collector.sv
// Scans a 4:1 mux by stepping its selects, lets each select settle, samples
// the mux output and presents the four collected bits as one held word.
// Latency: valid rises 4*(SETTLE_CYCLES+1) edges after start is taken in IDLE.
module mux_scan_collector #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       ack,
  input  logic       mux_in,
  output logic [1:0] sel,
  output logic [3:0] data,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Last settle count before the mux output is trusted.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] shadow_q, shadow_d;
  logic [1:0] sel_d;
  logic [3:0] data_d;
  logic       valid_d;
  logic       busy_d;

  // Register state and all outputs; reset clears everything asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      shadow_q <= 4'd0;
      sel      <= 2'd0;
      data     <= 4'd0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sel      <= sel_d;
      data     <= data_d;
      valid    <= valid_d;
      busy     <= busy_d;
    end
  end

  // Next-state and next-output logic; every register holds unless a state acts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sel_d    = sel;
    data_d   = data;
    valid_d  = valid;
    busy_d   = busy;

    case (state_q)
      IDLE: begin
        sel_d   = 2'd0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        if (start) begin
          state_d = SETTLE;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
        end
      end

      SETTLE: begin
        // Select is held constant while the mux output settles.
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        // The only place mux_in is observed.
        shadow_d[sel] = mux_in;
        if (sel != 2'd3) begin
          sel_d   = sel + 2'd1;
          cnt_d   = 4'd0;
          state_d = SETTLE;
        end else begin
          // Publish the word including the bit sampled this very cycle.
          state_d = HOLD;
          data_d  = shadow_d;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          sel_d   = 2'd0;
        end
      end

      HOLD: begin
        // Word stays until consumed; start is not queued here.
        if (ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_collector.sv
// Directed bench for mux_scan_collector: a behavioural 4:1 mux model feeds
// each instance; expected values are hand-derived from the scan timing.
// Inputs are driven and outputs checked on the falling clock edge.
module tb_mux_scan_collector;

  logic       clock;
  logic       reset;
  logic       start;
  logic       ack;
  logic [3:0] model;
  logic       mux_in;
  logic [1:0] sel;
  logic [3:0] data;
  logic       valid;
  logic       busy;

  // Second instance: SETTLE_CYCLES=1 with start and ack tied high.
  logic       rst1;
  logic [3:0] model1;
  logic       mux_in1;
  logic [1:0] sel1;
  logic [3:0] data1;
  logic       valid1;
  logic       busy1;

  int errors = 0;
  int checks = 0;

  assign mux_in  = model[sel];
  assign mux_in1 = model1[sel1];

  mux_scan_collector #(.SETTLE_CYCLES(2)) u_dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .ack   (ack),
    .mux_in(mux_in),
    .sel   (sel),
    .data  (data),
    .valid (valid),
    .busy  (busy)
  );

  mux_scan_collector #(.SETTLE_CYCLES(1)) u_dut1 (
    .clock (clock),
    .reset (rst1),
    .start (1'b1),
    .ack   (1'b1),
    .mux_in(mux_in1),
    .sel   (sel1),
    .data  (data1),
    .valid (valid1),
    .busy  (busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    rst1   = 1'b1;
    start  = 1'b0;
    ack    = 1'b0;
    model  = 4'b1010;
    model1 = 4'b1001;

    // Reset state.
    #2;
    check("rst_sel",   {2'b00, sel}, 4'd0);
    check("rst_data",  data,         4'd0);
    check("rst_valid", {3'b0, valid}, 4'd0);
    check("rst_busy",  {3'b0, busy},  4'd0);
    @(negedge clock);
    reset = 1'b0;

    // Basic scan of 1010: 12 busy cycles, sel 0..3 each held 3 cycles.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clock);
      check("scan1_busy",  {3'b0, busy},  4'd1);
      check("scan1_valid", {3'b0, valid}, 4'd0);
      check("scan1_sel",   {2'b00, sel},  4'((k - 1) / 3));
      check("scan1_data",  data,          4'd0);
    end
    @(negedge clock);
    check("scan1_done_valid", {3'b0, valid}, 4'd1);
    check("scan1_done_data",  data,          4'b1010);
    check("scan1_done_busy",  {3'b0, busy},  4'd0);
    check("scan1_done_sel",   {2'b00, sel},  4'd0);

    // Hold without ack for 20 cycles while start toggles.
    for (int k = 0; k < 20; k++) begin
      start = ~start;
      @(negedge clock);
      check("hold_valid", {3'b0, valid}, 4'd1);
      check("hold_data",  data,          4'b1010);
      check("hold_busy",  {3'b0, busy},  4'd0);
      check("hold_sel",   {2'b00, sel},  4'd0);
    end
    start = 1'b0;
    ack   = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    check("ack_valid", {3'b0, valid}, 4'd0);
    check("ack_data",  data,          4'b1010);
    check("ack_busy",  {3'b0, busy},  4'd0);

    // Inputs change from 0110 to 1111 while sel==2 settles -> 1110.
    model = 4'b0110;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    check("chg_sel2", {2'b00, sel}, 4'd2);
    check("chg_old_data_visible", data, 4'b1010);
    model = 4'b1111;
    repeat (6) @(negedge clock);
    check("chg_valid", {3'b0, valid}, 4'd1);
    check("chg_data",  data,          4'b1110);

    // ack and start together in the first HOLD cycle: start is dropped.
    ack   = 1'b1;
    start = 1'b1;
    @(negedge clock);
    check("both_valid", {3'b0, valid}, 4'd0);
    check("both_busy",  {3'b0, busy},  4'd0);
    ack   = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check("both_idle_busy", {3'b0, busy}, 4'd0);
    check("both_idle_sel",  {2'b00, sel}, 4'd0);
    check("both_data_kept", data,         4'b1110);
    @(negedge clock);
    check("both_idle_busy2", {3'b0, busy}, 4'd0);

    // Reset mid-scan at sel==2, then a fresh scan of 0101.
    model = 4'b1100;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    check("mid_sel2", {2'b00, sel},  4'd2);
    check("mid_busy", {3'b0, busy},  4'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_sel",   {2'b00, sel},  4'd0);
    check("arst_data",  data,          4'd0);
    check("arst_valid", {3'b0, valid}, 4'd0);
    check("arst_busy",  {3'b0, busy},  4'd0);
    @(negedge clock);
    reset = 1'b0;
    model = 4'b0101;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    ack   = 1'b1;   // ack outside HOLD must have no effect
    check("post_busy", {3'b0, busy}, 4'd1);
    repeat (10) @(negedge clock);
    check("post_busy11",  {3'b0, busy},  4'd1);
    check("post_valid11", {3'b0, valid}, 4'd0);
    check("post_sel11",   {2'b00, sel},  4'd3);
    ack = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("post_valid", {3'b0, valid}, 4'd1);
    check("post_data",  data,          4'b0101);
    check("post_busy13", {3'b0, busy}, 4'd0);
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    check("post_ack_valid", {3'b0, valid}, 4'd0);

    // SETTLE_CYCLES=1, start/ack tied high: valid every 10 cycles.
    rst1 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      check("fast_valid", {3'b0, valid1}, 4'((k % 10) == 9));
      check("fast_busy",  {3'b0, busy1},  4'((k % 10) >= 1 && (k % 10) <= 8));
      if ((k % 10) == 9) begin
        check("fast_data", data1, 4'b1001);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
